my_ram8_16: RTL and testbench

//  8-entry x 16-bit register bank with a registered, flow-controlled read port.

---
 rtl/my_ram8_16.sv | 157 +++++++++++++++
 tb/tb_my_ram8_16.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_ram8_16.sv
// my_ram8_16: 8-entry x 16-bit register bank with a registered, flow-controlled read port.
// The eight words feed an 8-way word select that the read address drives. The selected
// word is captured into a one-entry output buffer that uses a valid/ack handshake.
//
// Optional feature macro: MY_RAM8_SCAN_EN
//   When defined, a scan FSM reads the whole bank in address order through the read port.
//   When undefined, scan_start is ignored and scan_busy/scan_done are tied low.
//
// Ports:
//   clk        in   1   clock; all state updates on posedge
//   rst_n      in   1   asynchronous active-low reset
//   load       in   1   write enable for the current cycle
//   wr_addr    in   3   write address
//   in         in   16  write data
//   rd_req     in   1   read request; accepted when rd_req && rd_ready
//   rd_addr    in   3   read address, sampled on acceptance
//   rd_ready   out  1   read port can accept (!rd_valid || rd_ack)
//   rd_valid   out  1   rd_data holds a completed read
//   rd_data    out  16  read result, stable while rd_valid && !rd_ack
//   rd_ack     in   1   consumer takes rd_data this cycle
//   scan_start in   1   one-cycle pulse: start a full-bank scan
//   scan_busy  out  1   scan in progress
//   scan_done  out  1   one-cycle pulse after the last scan word is accepted
module my_ram8_16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] in,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ack,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mux_out;
  logic             req_eff;
  logic [2:0]       addr_eff;
  logic             accept;

  assign rd_ready = !rd_valid || rd_ack;
  assign accept   = req_eff && rd_ready;

  // Word register bank. The read path samples mem before this edge's write lands,
  // so a same-cycle read/write to one address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[wr_addr] <= in;
    end
  end

  // 8-way word select (a..h = mem[0..7], sel = effective read address).
  always_comb begin
    mux_out = '0;
    case (addr_eff)
      3'd0: mux_out = mem[0];
      3'd1: mux_out = mem[1];
      3'd2: mux_out = mem[2];
      3'd3: mux_out = mem[3];
      3'd4: mux_out = mem[4];
      3'd5: mux_out = mem[5];
      3'd6: mux_out = mem[6];
      3'd7: mux_out = mem[7];
      default: mux_out = '0;
    endcase
  end

  // One-entry output buffer. rd_data keeps its last value when the buffer drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (accept) begin
      rd_valid <= 1'b1;
      rd_data  <= mux_out;
    end else if (rd_ack) begin
      rd_valid <= 1'b0;
    end
  end

`ifdef MY_RAM8_SCAN_EN
  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic       done_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      scan_done <= done_nx;
    end
  end

  // While scanning, the FSM owns the read request; the buffer's own ready still
  // gates acceptance, so backpressure simply holds ptr.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    done_nx  = 1'b0;
    req_eff  = rd_req;
    addr_eff = rd_addr;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_nx = SCAN;
          ptr_nx   = '0;
        end
      end
      SCAN: begin
        req_eff  = 1'b1;
        addr_eff = ptr;
        if (rd_ready) begin
          ptr_nx = ptr + 3'd1;
          if (ptr == 3'd7) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign scan_busy = (state == SCAN);
`else
  logic unused_scan_start;

  assign unused_scan_start = scan_start;
  assign req_eff           = rd_req;
  assign addr_eff          = rd_addr;
  assign scan_busy         = 1'b0;
  assign scan_done         = 1'b0;
`endif

endmodule

// File: tb/tb_my_ram8_16.sv
// Self-checking bench for my_ram8_16: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the bank and its read buffer.
module tb_my_ram8_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [2:0]  wr_addr;
  logic [15:0] in_d;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        scan_start;
  logic        scan_busy;
  logic        scan_done;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] PAT [8] = '{16'h8000, 16'h2000, 16'h0800, 16'h0200,
                                      16'h0080, 16'h0020, 16'h0008, 16'h0002};

  // Behavioural model state
  logic [15:0] m_mem [8];
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_busy;
  logic        m_done;
  int          m_ptr;

  my_ram8_16 #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .wr_addr(wr_addr), .in(in_d),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ack(rd_ack), .scan_start(scan_start),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_ptr   = 0;
  endtask

  task automatic idle_inputs();
    load = 1'b0; wr_addr = 3'd0; in_d = 16'h0000;
    rd_req = 1'b0; rd_addr = 3'd0; rd_ack = 1'b0; scan_start = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic cycle();
    logic rdy, req, acc;
    int   addr;
    rdy = !m_valid || rd_ack;
    if (m_busy) begin
      req = 1'b1; addr = m_ptr;
    end else begin
      req = rd_req; addr = int'(rd_addr);
    end
    acc = req && rdy;
    @(posedge clk);
    m_done = 1'b0;
    if (acc) begin
      m_data  = m_mem[addr];
      m_valid = 1'b1;
    end else if (rd_ack) begin
      m_valid = 1'b0;
    end
    if (load) m_mem[wr_addr] = in_d;
`ifdef MY_RAM8_SCAN_EN
    if (m_busy) begin
      if (acc) begin
        m_ptr++;
        if (m_ptr == 8) begin
          m_busy = 1'b0; m_done = 1'b1; m_ptr = 0;
        end
      end
    end else if (scan_start) begin
      m_busy = 1'b1; m_ptr = 0;
    end
`endif
    #1;
  endtask

  task automatic load_bank();
    idle_inputs();
    rd_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; wr_addr = 3'(i); in_d = PAT[i];
      cycle();
    end
    idle_inputs();
    rd_ack = 1'b1;
    cycle();
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0000 || rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rd: valid=%b data=%h ready=%b required valid=0 data=0000 ready=1",
               rd_valid, rd_data, rd_ready);
    end
    checks++;
    if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_scan: busy=%b done=%b required 0 0", scan_busy, scan_done);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_readback();
    load_bank();
    rd_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr = 3'(i);
      cycle();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== PAT[i]) begin
        errors++;
        $display("FAIL readback[%0d]: valid=%b data=%h required valid=1 data=%h",
                 i, rd_valid, rd_data, PAT[i]);
      end
    end
    rd_req = 1'b0;
    cycle();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== PAT[7]) begin
      errors++;
      $display("FAIL readback_drain: valid=%b data=%h required valid=0 data=%h",
               rd_valid, rd_data, PAT[7]);
    end
  endtask

  task automatic test_same_addr();
    idle_inputs();
    rd_ack = 1'b1;
    load = 1'b1; wr_addr = 3'd3; in_d = 16'hBEEF;
    rd_req = 1'b1; rd_addr = 3'd3;
    cycle();
    checks++;
    if (rd_data !== 16'h0200) begin
      errors++;
      $display("FAIL same_addr_old: data=%h required 0200", rd_data);
    end
    load = 1'b0;
    cycle();
    checks++;
    if (rd_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL same_addr_new: data=%h required beef", rd_data);
    end
    rd_req = 1'b0;
    load = 1'b1; wr_addr = 3'd3; in_d = 16'h0200;
    cycle();
    idle_inputs();
  endtask

  task automatic test_hold();
    idle_inputs();
    rd_req = 1'b1; rd_addr = 3'd5;
    cycle();
    rd_addr = 3'd1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h0020 || rd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b data=%h ready=%b required valid=1 data=0020 ready=0",
                 i, rd_valid, rd_data, rd_ready);
      end
    end
    rd_req = 1'b0; rd_ack = 1'b1;
    #1;
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_ready_on_ack: ready=%b required 1", rd_ready);
    end
    cycle();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0020) begin
      errors++;
      $display("FAIL hold_release: valid=%b data=%h required valid=0 data=0020", rd_valid, rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      load       = ($urandom_range(0, 2) == 0);
      wr_addr    = 3'($urandom_range(0, 7));
      in_d       = 16'($urandom);
      rd_req     = ($urandom_range(0, 9) < 7);
      rd_addr    = 3'($urandom_range(0, 7));
      rd_ack     = ($urandom_range(0, 1) == 1);
      scan_start = ($urandom_range(0, 39) == 0);
      #1;
      checks++;
      if (rd_ready !== (!m_valid || rd_ack)) begin
        errors++;
        $display("FAIL rand_ready[%0d]: ready=%b required %b", n, rd_ready, !m_valid || rd_ack);
      end
      cycle();
      checks++;
      if (rd_valid !== m_valid || (m_valid && rd_data !== m_data)) begin
        errors++;
        $display("FAIL rand_read[%0d]: valid=%b data=%h required valid=%b data=%h",
                 n, rd_valid, rd_data, m_valid, m_data);
      end
      checks++;
      if (scan_busy !== m_busy || scan_done !== m_done) begin
        errors++;
        $display("FAIL rand_scan[%0d]: busy=%b done=%b required busy=%b done=%b",
                 n, scan_busy, scan_done, m_busy, m_done);
      end
    end
    idle_inputs();
    rd_ack = 1'b1;
    for (int n = 0; n < 20 && (m_busy || m_valid); n++) cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    load_bank();
    rd_req = 1'b1; rd_addr = 3'd0;
    cycle();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h8000) begin
      errors++;
      $display("FAIL pre_reset_read: valid=%b data=%h required valid=1 data=8000", rd_valid, rd_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h required valid=0 data=0000", rd_valid, rd_data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    rd_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr = 3'(i);
      cycle();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'h0000) begin
        errors++;
        $display("FAIL post_reset_read[%0d]: valid=%b data=%h required valid=1 data=0000",
                 i, rd_valid, rd_data);
      end
    end
    idle_inputs();
    rd_ack = 1'b1;
    cycle();
    idle_inputs();
  endtask

`ifdef MY_RAM8_SCAN_EN
  task automatic test_scan();
    logic [15:0] got [$];
    int          done_pulses;
    bit          hit;
    load_bank();
    rd_req = 1'b1; rd_addr = 3'd6;
    scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    checks++;
    if (scan_busy !== 1'b1) begin
      errors++;
      $display("FAIL scan_busy_start: busy=%b required 1", scan_busy);
    end
    done_pulses = 0;
    for (int n = 0; n < 40; n++) begin
      rd_ack = n[0];
      if (rd_valid && rd_ack && (scan_busy || scan_done || got.size() < 8)) got.push_back(rd_data);
      cycle();
      if (scan_done === 1'b1) done_pulses++;
      checks++;
      if (scan_busy !== m_busy || scan_done !== m_done || rd_valid !== m_valid ||
          (m_valid && rd_data !== m_data)) begin
        errors++;
        $display("FAIL scan_cycle[%0d]: busy=%b done=%b valid=%b data=%h required %b %b %b %h",
                 n, scan_busy, scan_done, rd_valid, rd_data, m_busy, m_done, m_valid, m_data);
      end
    end
    rd_req = 1'b0;
    // The first consumed word may be the external read issued alongside scan_start.
    if (got.size() > 0 && got[0] === PAT[6] && got.size() == 9) void'(got.pop_front());
    checks++;
    if (got.size() != 8 || done_pulses != 1) begin
      errors++;
      $display("FAIL scan_count: words=%0d done_pulses=%0d required words=8 done_pulses=1",
               got.size(), done_pulses);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== PAT[i]) begin
        errors++;
        $display("FAIL scan_word[%0d]: data=%h required %h", i, got[i], PAT[i]);
      end
    end
    idle_inputs();
    rd_ack = 1'b1;
    cycle();
    scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cycle();
      if (rd_valid === 1'b1 && rd_data === PAT[3]) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL scan_word4_wait: word 0200 not seen within 20 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (scan_busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_reset: busy=%b valid=%b required 0 0", scan_busy, rd_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    done_pulses = 0;
    for (int n = 0; n < 15; n++) begin
      cycle();
      if (scan_done !== 1'b0 || scan_busy !== 1'b0) done_pulses++;
    end
    checks++;
    if (done_pulses != 0) begin
      errors++;
      $display("FAIL scan_after_reset: busy/done high in %0d cycles required 0", done_pulses);
    end
    idle_inputs();
  endtask
`else
  task automatic test_no_scan();
    int bad;
    load_bank();
    rd_ack = 1'b1;
    rd_req = 1'b1; rd_addr = 3'd2;
    scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0800) begin
      errors++;
      $display("FAIL noscan_read: valid=%b data=%h required valid=1 data=0800", rd_valid, rd_data);
    end
    rd_req = 1'b0;
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (scan_busy !== 1'b0 || scan_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL noscan_flags: busy/done high in %0d cycles required 0", bad);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0800) begin
      errors++;
      $display("FAIL noscan_idle: valid=%b data=%h required valid=0 data=0800", rd_valid, rd_data);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_readback();
    test_same_addr();
    test_hold();
    test_random();
    test_reset_mid();
`ifdef MY_RAM8_SCAN_EN
    test_scan();
`else
    test_no_scan();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
